// File: rtl/utc_digit_formatter_pkg.sv
// Shared types and constants for the UTC digit formatter.
package utc_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    COMMIT
  } state_t;

  localparam logic [3:0]  BLANK      = 4'hF;
  localparam logic [7:0]  DATE_POINT = 8'b11101011;
  localparam logic [7:0]  TIME_POINT = 8'b11011011;

  localparam int unsigned DATE_LAT   = 35;
  localparam int unsigned TIME_LAT   = 28;
  localparam int unsigned YEAR_CLAMP = 9999;

  // Engine input width and per-field shift counts.
  localparam int unsigned ENG_W        = 14;
  localparam logic [3:0]  YEAR_SHIFTS  = 4'd14;
  localparam logic [3:0]  FIELD_SHIFTS = 4'd7;

endpackage

// File: rtl/utc_digit_formatter_if.sv
// Calendar-field inputs and display outputs of the UTC digit formatter.
interface utc_digit_formatter_if #(
  parameter int unsigned YEAR_W = 14
);
  logic              mode;
  logic [YEAR_W-1:0] year;
  logic [3:0]        month;
  logic [4:0]        day;
  logic [4:0]        hour;
  logic [5:0]        minute;
  logic [5:0]        second;

  logic [31:0]       digits;
  logic [7:0]        point;
  logic              valid;
  logic              busy;
  logic              update;
  logic              year_ovf;

  modport master (
    output mode, year, month, day, hour, minute, second,
    input  digits, point, valid, busy, update, year_ovf
  );

  modport slave (
    input  mode, year, month, day, hour, minute, second,
    output digits, point, valid, busy, update, year_ovf
  );
endinterface

// File: rtl/utc_digit_formatter_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD engine, 4 BCD digits out.
module bin2bcd_seq #(
  parameter int unsigned IN_W = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift_en,
  input  logic [IN_W-1:0] bin_in,
  output logic [15:0]     bcd_out
);

  logic [IN_W-1:0] bin_q;
  logic [15:0]     bcd_q;
  logic [15:0]     bcd_adj;

  // Add 3 to every BCD nibble that is 5 or more ahead of the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load clears the BCD accumulator; each shift moves one binary MSB in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load) begin
      bin_q <= bin_in;
      bcd_q <= '0;
    end else if (shift_en) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
    end
  end

  assign bcd_out = bcd_q;

endmodule

// File: rtl/utc_digit_formatter.sv
// Converts UTC calendar fields to eight display digits through one shared
// sequential BCD engine; results are committed atomically.
module utc_digit_formatter #(
  parameter int unsigned YEAR_W     = 14,
  parameter logic [7:0]  DATE_POINT = utc_fmt_pkg::DATE_POINT,
  parameter logic [7:0]  TIME_POINT = utc_fmt_pkg::TIME_POINT,
  parameter logic [3:0]  BLANK      = utc_fmt_pkg::BLANK
) (
  input  logic                 clk,
  input  logic                 reset,
  utc_digit_formatter_if.slave bus
);
  import utc_fmt_pkg::*;

  state_t            state_q, state_d;

  logic              snap_valid;
  logic              snap_mode;
  logic [YEAR_W-1:0] snap_year;
  logic [3:0]        snap_month;
  logic [4:0]        snap_day;
  logic [4:0]        snap_hour;
  logic [5:0]        snap_minute;
  logic [5:0]        snap_second;

  logic [1:0]        field_q;
  logic [3:0]        shift_q;
  logic [31:0]       shadow_q;
  logic              shadow_ovf;

  logic [31:0]       digits_q;
  logic [7:0]        point_q;
  logic              valid_q, busy_q, update_q, ovf_q;

  logic              start, capture, eng_load, eng_shift, store_en, commit;
  logic              year_big;
  logic [3:0]        field_len;
  logic [ENG_W-1:0]  eng_in;
  logic [15:0]       bcd;

  assign start = !snap_valid ||
                 ({bus.mode, bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second} !=
                  {snap_mode, snap_year, snap_month, snap_day, snap_hour, snap_minute, snap_second});

  assign year_big  = 32'(snap_year) > YEAR_CLAMP;
  assign field_len = (!snap_mode && field_q == 2'd0) ? YEAR_SHIFTS : FIELD_SHIFTS;

  // Select the snapshot field for the engine; 2-digit fields sit MSB-aligned
  // so that 7 shifts consume exactly their 7 zero-extended bits.
  always_comb begin
    eng_in = '0;
    if (!snap_mode) begin
      case (field_q)
        2'd0:    eng_in = year_big ? ENG_W'(YEAR_CLAMP) : ENG_W'(snap_year);
        2'd1:    eng_in = {3'b000, snap_month, 7'b0};
        2'd2:    eng_in = {2'b00, snap_day, 7'b0};
        default: eng_in = '0;
      endcase
    end else begin
      case (field_q)
        2'd0:    eng_in = {2'b00, snap_hour, 7'b0};
        2'd1:    eng_in = {1'b0, snap_minute, 7'b0};
        2'd2:    eng_in = {1'b0, snap_second, 7'b0};
        default: eng_in = '0;
      endcase
    end
  end

  bin2bcd_seq #(.IN_W(ENG_W)) u_bcd (
    .clk      (clk),
    .reset    (reset),
    .load     (eng_load),
    .shift_en (eng_shift),
    .bin_in   (eng_in),
    .bcd_out  (bcd)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: LOAD, SHIFT x N, STORE per field, then COMMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (shift_q == field_len - 4'd1) state_d = STORE;
      STORE:   state_d = (field_q == 2'd2) ? COMMIT : LOAD;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    capture   = (state_q == IDLE) && start;
    eng_load  = (state_q == LOAD);
    eng_shift = (state_q == SHIFT);
    store_en  = (state_q == STORE);
    commit    = (state_q == COMMIT);
  end

  // Snapshot, field sequencing, shadow digits and committed outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_valid  <= 1'b0;
      snap_mode   <= 1'b0;
      snap_year   <= '0;
      snap_month  <= '0;
      snap_day    <= '0;
      snap_hour   <= '0;
      snap_minute <= '0;
      snap_second <= '0;
      field_q     <= '0;
      shift_q     <= '0;
      shadow_q    <= '1;
      shadow_ovf  <= 1'b0;
      digits_q    <= '1;
      point_q     <= '1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      update_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      update_q <= commit;
      if (capture) begin
        snap_valid  <= 1'b1;
        snap_mode   <= bus.mode;
        snap_year   <= bus.year;
        snap_month  <= bus.month;
        snap_day    <= bus.day;
        snap_hour   <= bus.hour;
        snap_minute <= bus.minute;
        snap_second <= bus.second;
        field_q     <= '0;
        busy_q      <= 1'b1;
      end
      if (eng_load) begin
        shift_q <= '0;
        if (!snap_mode && field_q == 2'd0) shadow_ovf <= year_big;
      end
      if (eng_shift) shift_q <= shift_q + 4'd1;
      if (store_en) begin
        field_q <= field_q + 2'd1;
        case ({snap_mode, field_q})
          3'b0_00: shadow_q[31:16] <= bcd;
          3'b0_01: shadow_q[15:8]  <= bcd[7:0];
          3'b0_10: shadow_q[7:0]   <= bcd[7:0];
          3'b1_00: shadow_q[31:24] <= bcd[7:0];
          3'b1_01: shadow_q[19:12] <= bcd[7:0];
          3'b1_10: shadow_q[7:0]   <= bcd[7:0];
          default: ;
        endcase
      end
      if (commit) begin
        digits_q <= snap_mode ? {shadow_q[31:24], BLANK, shadow_q[19:12], BLANK, shadow_q[7:0]}
                              : shadow_q;
        point_q  <= snap_mode ? TIME_POINT : DATE_POINT;
        ovf_q    <= !snap_mode && shadow_ovf;
        valid_q  <= 1'b1;
        busy_q   <= 1'b0;
      end
    end
  end

  assign bus.digits   = digits_q;
  assign bus.point    = point_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.update   = update_q;
  assign bus.year_ovf = ovf_q;

endmodule
